// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with registered one-hot grant, encoded index
// and a per-ownership hold limit that keeps any requester from starving.
module rr_priority_arbiter #(
   parameter int N        = 8,
   parameter int IDXW     = 3,
   parameter int MAX_HOLD = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            gnt_valid,
   output logic            gnt_new
);

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              new_q, new_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [7:0]        hold_q, hold_d;

   logic              win_found;
   logic [IDXW-1:0]   win_idx;
   logic [IDXW:0]     scan;
   logic              lim_hit;
   logic              arb;
   logic [IDXW-1:0]   ptr_next;
   logic [7:0]        hold_inc;

   // Scan ptr, ptr+1, ... modulo N; first live request wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan      = '0;
      for (int k = 0; k < N; k++) begin
         scan = {1'b0, ptr_q} + (IDXW+1)'(k);
         if (scan >= (IDXW+1)'(N))
            scan = scan - (IDXW+1)'(N);
         if (!win_found && req[scan[IDXW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan[IDXW-1:0];
         end
      end
   end

   assign lim_hit  = (MAX_HOLD != 0) && (hold_q == 8'(MAX_HOLD));
   assign arb      = (state_q == IDLE) || !req[idx_q] || lim_hit;
   assign ptr_next = (win_idx == IDXW'(N-1)) ? '0 : win_idx + 1'b1;
   assign hold_inc = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      new_d   = 1'b0;
      ptr_d   = ptr_q;
      hold_d  = hold_inc;
      if (arb) begin
         if (win_found) begin
            state_d = OWNED;
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
            idx_d   = win_idx;
            new_d   = 1'b1;
            ptr_d   = ptr_next;
            hold_d  = 8'd1;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            hold_d  = 8'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         new_q   <= 1'b0;
         ptr_q   <= '0;
         hold_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         new_q   <= new_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = (state_q == OWNED);
   assign gnt_new   = new_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed-vector scoreboard bench for rr_priority_arbiter (N=8, MAX_HOLD=4).
module tb_rr_priority_arbiter;

   localparam int N    = 8;
   localparam int IDXW = 3;

   typedef struct {
      logic [N-1:0] gnt;
      int           idx;
      logic         valid;
      logic         nw;
      string        name;
   } exp_t;

   bit              clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N-1:0]    gnt;
   logic [IDXW-1:0] gnt_idx;
   logic            gnt_valid;
   logic            gnt_new;

   exp_t expq[$];
   int   vectors = 0;
   int   errs    = 0;

   always #5 clk = ~clk;

   rr_priority_arbiter #(.N(N), .IDXW(IDXW), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .gnt_new   (gnt_new)
   );

   // Drive one cycle; expected values describe outputs after this edge.
   task automatic step(input logic r, input logic [N-1:0] q,
                       input int idx, input logic v, input logic nw,
                       input string nm);
      exp_t e;
      logic [N-1:0] one;
      one    = 1;
      rst    = r;
      req    = q;
      @(posedge clk);
      e.gnt   = v ? (one << idx) : '0;
      e.idx   = v ? idx : 0;
      e.valid = v;
      e.nw    = nw;
      e.name  = nm;
      expq.push_back(e);
      #1;
   endtask

   // Monitor: outputs are presented every cycle after the edge.
   always @(negedge clk) begin
      if (expq.size() != 0) begin
         exp_t e;
         e = expq.pop_front();
         vectors++;
         if (gnt !== e.gnt || int'(gnt_idx) != e.idx ||
             gnt_valid !== e.valid || gnt_new !== e.nw) begin
            errs++;
            $display("FAIL %s: got gnt=%h idx=%0d valid=%b new=%b want gnt=%h idx=%0d valid=%b new=%b",
                     e.name, gnt, gnt_idx, gnt_valid, gnt_new,
                     e.gnt, e.idx, e.valid, e.nw);
         end
      end
   end

   initial begin
      rst = 1'b1;
      req = 8'hFF;

      step(1, 8'hFF, 0, 0, 0, "rst_hold0");
      step(1, 8'hFF, 0, 0, 0, "rst_hold1");

      // All request: owners 0..7 then wrap to 0, 4 cycles each
      for (int o = 0; o < 9; o++)
         for (int c = 0; c < 4; c++)
            step(0, 8'hFF, o % 8, 1, c == 0, "round_robin");

      step(0, 8'h10, 4, 1, 1, "single_grant");
      step(0, 8'h10, 4, 1, 0, "single_hold1");
      step(0, 8'h10, 4, 1, 0, "single_hold2");
      step(0, 8'h10, 4, 1, 0, "single_hold3");
      step(0, 8'h00, 0, 0, 0, "single_drop");
      step(0, 8'h00, 0, 0, 0, "idle");

      step(0, 8'h04, 2, 1, 1, "handoff_own2");
      step(0, 8'h64, 2, 1, 0, "no_preempt");
      step(0, 8'h60, 5, 1, 1, "handoff_to5");
      step(0, 8'h00, 0, 0, 0, "handoff_idle");

      for (int c = 1; c <= 10; c++)
         step(0, 8'h08, 3, 1, (c == 1) || (c == 5) || (c == 9),
              "sole_limit");

      step(0, 8'h40, 6, 1, 1, "own6");
      step(0, 8'h40, 6, 1, 0, "own6_hold");
      step(1, 8'h40, 0, 0, 0, "mid_reset");
      step(0, 8'h84, 2, 1, 1, "post_reset_ptr0");
      step(0, 8'h00, 0, 0, 0, "final_idle");

      for (int i = 0; i < 10 && expq.size() != 0; i++)
         @(posedge clk);
      if (expq.size() != 0) begin
         errs++;
         $display("FAIL drain: %0d vectors left unchecked, want 0",
                  expq.size());
      end
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Built around a rotating priority-encoder search.
- Issues a registered one-hot grant plus an encoded index, holds the grant while the owner keeps requesting, and enforces a maximum hold time to prevent starvation.
- Sits in front of any shared datapath block that needs exactly one active user per cycle.

Parameters:
- N, 8, number of requesters (2..16).
- IDXW, 3, width of the grant index; must equal ceil(log2(N)).
- MAX_HOLD, 4, maximum consecutive grant cycles per ownership (1..255); 0 = unlimited.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- gnt  output  N  one-hot grant, registered; all zeros when idle.
- gnt_idx  output  IDXW  index of the current owner; 0 when idle.
- gnt_valid  output  1  high while a grant is active.
- gnt_new  output  1  single-cycle pulse on every cycle a new grant is issued, including a re-grant to the same requester.

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - gnt=0, gnt_idx=0, gnt_valid=0, gnt_new=0.
  - Internal ptr=0, hold_cnt=0.
  - req is ignored while rst=1.
- Internal state:
  - ptr (IDXW bits) is the highest-priority index for the next arbitration.
  - hold_cnt (8 bits) counts the cycles the current owner has held the grant.
- Two states: IDLE (gnt_valid=0) and OWNED (gnt_valid=1).
- Arbitrate condition (evaluated every edge):
  - state is IDLE, or
  - req[gnt_idx]=0 (owner released), or
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
- Winner search:
  - Scan indices ptr, ptr+1, …, ptr+N-1, modulo N.
  - The first index with req=1 wins.
  - Pure combinational rotate-and-encode from registered ptr and live req.
- On arbitrate with a winner w:
  - gnt<=onehot(w), gnt_idx<=w, gnt_valid<=1, gnt_new<=1, hold_cnt<=1.
  - ptr<=(w+1) mod N; wrap 7->0 for N=8.
- On arbitrate with no request: go to IDLE; gnt=0, gnt_idx=0, gnt_valid=0, gnt_new=0, hold_cnt=0; ptr unchanged.
- No arbitrate (owner keeps request, under limit): outputs held, gnt_new<=0, hold_cnt<=hold_cnt+1 (saturates at 255 when MAX_HOLD=0).
- Latency: req asserted in cycle t -> gnt visible after edge t+1.
- Handoff: owner drops req with others pending -> next owner granted on the next edge, with no idle cycle.
- Hold limit reached while the owner still requests:
  - Because ptr=owner+1, the owner has the lowest priority, so other requesters win first.
  - If the owner is the sole requester, it is re-granted with a gnt_new pulse and no gap.
- Requests arriving mid-ownership never preempt; they wait for release or the hold limit.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_new implies gnt_valid.
- Reset mid-ownership: the grant is dropped on that edge, ptr returns to 0, and the first arbitration after reset starts from index 0.

Test Plan (N=8, MAX_HOLD=4):
- Reset priority: rst=1 for 2 cycles with req=8'hFF -> gnt=0, gnt_valid=0 throughout. Deassert rst -> after the next edge gnt=8'h01, gnt_idx=0, gnt_new=1 for exactly one cycle.
- Single requester:
  - req=8'h10 -> next edge gnt=8'h10, gnt_idx=4.
  - Hold req for 3 cycles -> grant held, gnt_new=0.
  - Drop req -> next edge gnt=0, gnt_valid=0.
- Round robin: req=8'hFF held constantly -> owners 0,1,…,7,0 in that order, each owning exactly 4 cycles, a gnt_new pulse at each change, wrap from 7 to 0.
- Release handoff: owner idx 2, req=8'h64 -> drop req[2] -> next edge gnt_idx=5, gnt=8'h20, no idle cycle between grants.
- Sole requester at limit: only req[3] high for 10 cycles -> gnt_idx=3 continuously, gnt_new pulses at grant cycles 1, 5 and 9, gnt_valid never drops.
- Reset mid-ownership: owner idx 6, assert rst one cycle -> next edge gnt=0, gnt_valid=0. Release rst with req=8'h84 -> next edge gnt_idx=2 (search restarts at ptr=0).
